tile_load_responder: RTL and testbench

//  Responder side of the controller's load-request channel (sel / request_valid / finish).

---
 rtl/tile_load_responder.sv | 200 ++++++++++++++++++++
 tb/tb_tile_load_responder.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_load_responder.sv
// tile_load_responder: streams one C/A/B operand matrix from SRAM into the
// array's operand buffers on a one-hot load request, then pulses finish.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_valid, req_sel  load request strobe and one-hot matrix select (C/A/B)
//   finish, err         one-cycle completion pulse; err marks an illegal select
//   busy                high whenever a request is being serviced
//   sram_en, sram_addr  SRAM read port; sram_rdata is valid one cycle later
//   wr_valid, wr_ready  buffer write handshake (beat = wr_valid && wr_ready)
//   wr_sel, wr_idx      target buffer and word index within the matrix
//   wr_data             word being written
module tile_load_responder #(
    parameter int WIDTH   = 32,
    parameter int ENTRYS  = 1024,
    parameter int C_WORDS = 128,
    parameter int A_WORDS = 128,
    parameter int B_WORDS = 256,
    parameter int C_BASE  = 0,
    parameter int A_BASE  = 128,
    parameter int B_BASE  = 256,
    localparam int AW     = $clog2(ENTRYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [2:0]       req_sel,
    output logic             finish,
    output logic             err,
    output logic             busy,
    output logic             sram_en,
    output logic [AW-1:0]    sram_addr,
    input  logic [WIDTH-1:0] sram_rdata,
    output logic             wr_valid,
    input  logic             wr_ready,
    output logic [2:0]       wr_sel,
    output logic [8:0]       wr_idx,
    output logic [WIDTH-1:0] wr_data
);

    localparam logic [8:0]    C_N = 9'(C_WORDS);
    localparam logic [8:0]    A_N = 9'(A_WORDS);
    localparam logic [8:0]    B_N = 9'(B_WORDS);
    localparam logic [AW-1:0] C_B = AW'(C_BASE);
    localparam logic [AW-1:0] A_B = AW'(A_BASE);
    localparam logic [AW-1:0] B_B = AW'(B_BASE);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    state_t          state;
    logic [2:0]      sel_q;
    logic [8:0]      n_q;
    logic [AW-1:0]   base_q;
    logic [8:0]      issue_cnt;
    logic [8:0]      beat_cnt;
    logic            primed;
    logic            inflight;

    // two-entry read-data FIFO
    logic [WIDTH-1:0] fifo_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       occ;

    logic             legal;
    logic [8:0]       lat_n;
    logic [AW-1:0]    lat_base;
    logic             push;
    logic             pop;
    logic             issue;
    logic [2:0]       credit;
    logic [AW-1:0]    addr_sum;

    always_comb begin
        legal    = 1'b0;
        lat_n    = '0;
        lat_base = '0;
        case (req_sel)
            3'b001: begin
                legal    = 1'b1;
                lat_n    = C_N;
                lat_base = C_B;
            end
            3'b010: begin
                legal    = 1'b1;
                lat_n    = A_N;
                lat_base = A_B;
            end
            3'b100: begin
                legal    = 1'b1;
                lat_n    = B_N;
                lat_base = B_B;
            end
            default: begin
                legal    = 1'b0;
                lat_n    = '0;
                lat_base = '0;
            end
        endcase
    end

    assign push = inflight;
    assign pop  = wr_valid && wr_ready;

    // Words already held plus the one landing now, minus the one leaving now;
    // a new read is allowed only if its word will still fit when it lands.
    assign credit = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};

    // The first STREAM cycle is a setup cycle; reads start the cycle after.
    assign issue = (state == STREAM) && primed &&
                   (issue_cnt < n_q) && (credit < 3'd2);

    // Address wraps modulo the SRAM depth.
    assign addr_sum = base_q + AW'(issue_cnt);

    assign sram_en   = issue;
    assign sram_addr = issue ? addr_sum : '0;
    assign busy      = (state != IDLE);
    assign wr_valid  = (occ != 2'd0);
    assign wr_data   = wr_valid ? fifo_mem[rd_ptr] : '0;
    assign wr_idx    = wr_valid ? beat_cnt : '0;
    assign wr_sel    = sel_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            finish      <= 1'b0;
            err         <= 1'b0;
            sel_q       <= '0;
            n_q         <= '0;
            base_q      <= '0;
            issue_cnt   <= '0;
            beat_cnt    <= '0;
            primed      <= 1'b0;
            inflight    <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            occ         <= '0;
        end else begin
            inflight <= issue;
            if (push) begin
                fifo_mem[wr_ptr] <= sram_rdata;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr   <= ~rd_ptr;
                beat_cnt <= beat_cnt + 9'd1;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
            if (issue) begin
                issue_cnt <= issue_cnt + 9'd1;
            end

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (legal) begin
                            sel_q     <= req_sel;
                            n_q       <= lat_n;
                            base_q    <= lat_base;
                            issue_cnt <= '0;
                            beat_cnt  <= '0;
                            primed    <= 1'b0;
                            state     <= STREAM;
                        end else begin
                            finish <= 1'b1;
                            err    <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                STREAM: begin
                    primed <= 1'b1;
                    if (pop && (beat_cnt == n_q - 9'd1)) begin
                        finish <= 1'b1;
                        err    <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    finish <= 1'b0;
                    err    <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    finish <= 1'b0;
                    err    <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tile_load_responder.sv
// Testbench for tile_load_responder: table of load requests, hand-written
// corner sequences and randomized loads against an SRAM/beat model.
module tb_tile_load_responder;

    localparam int WIDTH = 32;
    localparam int AW    = 10;

    logic             clk;
    logic             rst;
    logic             req_valid;
    logic [2:0]       req_sel;
    logic             finish;
    logic             err;
    logic             busy;
    logic             sram_en;
    logic [AW-1:0]    sram_addr;
    logic [WIDTH-1:0] sram_rdata;
    logic             wr_valid;
    logic             wr_ready;
    logic [2:0]       wr_sel;
    logic [8:0]       wr_idx;
    logic [WIDTH-1:0] wr_data;

    tile_load_responder dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_sel    (req_sel),
        .finish     (finish),
        .err        (err),
        .busy       (busy),
        .sram_en    (sram_en),
        .sram_addr  (sram_addr),
        .sram_rdata (sram_rdata),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_sel     (wr_sel),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rmode = 0;
    int stall_until = 0;
    int e0 = 0;

    logic [31:0] mem [1024];

    int          q_idx  [$];
    logic [31:0] q_data [$];
    logic [2:0]  q_sel  [$];
    int          q_cyc  [$];

    int   en_cnt = 0;
    int   en_stall = 0;
    int   wv_cnt = 0;
    int   fin_cnt = 0;
    int   err_alone = 0;
    int   hold_bad = 0;
    int   fin_cyc = 0;
    logic fin_err = 0;
    logic fin_busy = 0;
    logic        prev_stall = 0;
    logic [31:0] prev_data = 0;
    logic [8:0]  prev_idx = 0;
    logic [2:0]  prev_sel = 0;

    int b0, en0, st0, wv0, fin0, ea0, hb0;

    typedef struct {
        logic [2:0] sel;
        int         mode;
        bit         exp_err;
        int         exp_n;
        int         exp_base;
    } vec_t;

    vec_t vecs [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM: data valid the cycle after the read enable
    always @(posedge clk) begin
        if (sram_en) sram_rdata <= mem[sram_addr];
    end

    // wr_ready pattern: 0 high, 1 toggle, 2 random, 3 low for a window
    initial begin
        wr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rmode)
                0: wr_ready = 1'b1;
                1: wr_ready = ~wr_ready;
                2: wr_ready = ($urandom_range(0, 3) != 0);
                3: wr_ready = (cyc >= stall_until);
                default: wr_ready = 1'b1;
            endcase
        end
    end

    always @(negedge clk) begin
        if (sram_en) begin
            en_cnt++;
            if (!wr_ready) en_stall++;
        end
        if (wr_valid) wv_cnt++;
        if (finish) begin
            fin_cnt++;
            fin_cyc  = cyc;
            fin_err  = err;
            fin_busy = busy;
        end
        if (err && !finish) err_alone++;
        if (prev_stall && !(wr_valid && wr_data == prev_data &&
                            wr_idx == prev_idx && wr_sel == prev_sel))
            hold_bad++;
        if (wr_valid && wr_ready) begin
            q_idx.push_back(int'(wr_idx));
            q_data.push_back(wr_data);
            q_sel.push_back(wr_sel);
            q_cyc.push_back(cyc);
        end
        prev_stall = wr_valid && !wr_ready;
        prev_data  = wr_data;
        prev_idx   = wr_idx;
        prev_sel   = wr_sel;
    end

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic snap();
        b0   = q_idx.size();
        en0  = en_cnt;
        st0  = en_stall;
        wv0  = wv_cnt;
        fin0 = fin_cnt;
        ea0  = err_alone;
        hb0  = hold_bad;
    endtask

    function automatic int model_n(input logic [2:0] s);
        case (s)
            3'b001:  return 128;
            3'b010:  return 128;
            3'b100:  return 256;
            default: return 0;
        endcase
    endfunction

    function automatic int model_base(input logic [2:0] s);
        case (s)
            3'b001:  return 0;
            3'b010:  return 128;
            3'b100:  return 256;
            default: return 0;
        endcase
    endfunction

    task automatic run_load(input logic [2:0] sel, input int mode,
                            input bit exp_err, input int exp_n,
                            input int exp_base, input string tag,
                            input bit chain, input int extra_at);
        int  k;
        int  lim;
        int  bad;
        int  nb;
        bit  done;
        rmode = mode;
        @(posedge clk);
        #1;
        snap();
        req_valid = 1'b1;
        req_sel   = sel;
        @(posedge clk);
        #1;
        e0          = cyc;
        stall_until = cyc + 20;
        req_valid   = 1'b0;
        req_sel     = 3'($urandom);
        lim  = 8 * exp_n + 40;
        k    = 0;
        done = 0;
        while (!done && k < lim) begin
            @(negedge clk);
            #1;
            k++;
            if (extra_at > 0 && k == extra_at) begin
                req_valid = 1'b1;
                req_sel   = 3'b001;
            end else begin
                req_valid = 1'b0;
            end
            if (fin_cnt > fin0) done = 1;
        end
        req_valid = 1'b0;
        check({tag, " finish_seen"}, int'(done), 1);
        check({tag, " err_at_finish"}, int'(fin_err), int'(exp_err));
        check({tag, " busy_at_finish"}, int'(fin_busy), 1);
        nb = q_idx.size() - b0;
        check({tag, " beats"}, nb, exp_n);
        check({tag, " sram_reads"}, en_cnt - en0, exp_n);
        bad = -1;
        for (int i = 0; i < nb; i++) begin
            if (bad < 0 &&
                (q_idx[b0+i] != i ||
                 q_data[b0+i] !== mem[(exp_base + i) % 1024] ||
                 q_sel[b0+i] !== sel))
                bad = i;
        end
        check({tag, " first_bad_beat"}, bad, -1);
        check({tag, " hold_violations"}, hold_bad - hb0, 0);
        if (exp_err) check({tag, " wr_valid_cycles"}, wv_cnt - wv0, 0);
        if (mode == 0) begin
            check({tag, " finish_cycle"}, fin_cyc - e0,
                  exp_err ? 0 : exp_n + 3);
            if (!exp_err && nb > 0) begin
                check({tag, " first_beat_cycle"}, q_cyc[b0] - e0, 3);
                check({tag, " last_beat_cycle"}, q_cyc[b0+nb-1] - e0,
                      exp_n + 2);
            end
        end
        if (mode == 3) begin
            tests++;
            if (en_stall - st0 > 2) begin
                fails++;
                $display("FAIL %s stalled_reads: got %0d, expected <= 2",
                         tag, en_stall - st0);
            end
        end
        if (!chain) begin
            repeat (3) @(negedge clk);
            #1;
            check({tag, " finish_pulse_cycles"}, fin_cnt - fin0, 1);
            check({tag, " err_without_finish"}, err_alone - ea0, 0);
            check({tag, " busy_after"}, int'(busy), 0);
            check({tag, " reads_after"}, en_cnt - en0, exp_n);
        end
    endtask

    initial begin
        int          k;
        logic [2:0]  s;
        bit          lg;

        vecs[0] = '{3'b001, 0, 1'b0, 128, 0};
        vecs[1] = '{3'b100, 1, 1'b0, 256, 256};
        vecs[2] = '{3'b010, 3, 1'b0, 128, 128};
        vecs[3] = '{3'b011, 0, 1'b1, 0, 0};
        vecs[4] = '{3'b000, 0, 1'b1, 0, 0};
        vecs[5] = '{3'b111, 1, 1'b1, 0, 0};
        vecs[6] = '{3'b100, 2, 1'b0, 256, 256};
        vecs[7] = '{3'b010, 0, 1'b0, 128, 128};

        for (int i = 0; i < 1024; i++) begin
            if (i < 256)      mem[i] = 32'(i);
            else if (i < 512) mem[i] = 32'h0000_B000 + 32'(i - 256);
            else              mem[i] = $urandom;
        end

        rst       = 1'b1;
        req_valid = 1'b0;
        req_sel   = 3'b000;
        repeat (3) @(negedge clk);
        #1;
        check("reset_ctrl_outputs",
              int'({finish, err, busy, sram_en, wr_valid}), 0);
        check("reset_data_outputs",
              int'(|{sram_addr, wr_sel, wr_idx, wr_data}), 0);
        rst = 1'b0;

        for (int v = 0; v < 8; v++) begin
            run_load(vecs[v].sel, vecs[v].mode, vecs[v].exp_err,
                     vecs[v].exp_n, vecs[v].exp_base,
                     $sformatf("vec%0d", v), 1'b0, 0);
        end

        // second request in the middle of an A load is ignored
        run_load(3'b010, 0, 1'b0, 128, 128, "midreq", 1'b0, 30);

        // reset in the middle of an A load
        rmode = 0;
        @(posedge clk);
        #1;
        snap();
        req_valid = 1'b1;
        req_sel   = 3'b010;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        k = 0;
        while (q_idx.size() - b0 < 50 && k < 400) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("rst_reached_beat50", q_idx.size() - b0, 50);
        rst = 1'b1;
        #1;
        check("rst_ctrl_outputs",
              int'({finish, err, busy, sram_en, wr_valid}), 0);
        check("rst_data_outputs",
              int'(|{sram_addr, wr_sel, wr_idx, wr_data}), 0);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        snap();
        repeat (20) @(negedge clk);
        #1;
        check("rst_no_finish", fin_cnt - fin0, 0);
        check("rst_no_reads", en_cnt - en0, 0);
        check("rst_idle", int'(busy), 0);
        run_load(3'b001, 0, 1'b0, 128, 0, "after_rst", 1'b0, 0);

        // A load requested in the IDLE cycle right after C finishes
        run_load(3'b001, 0, 1'b0, 128, 0, "chain_c", 1'b1, 0);
        run_load(3'b010, 0, 1'b0, 128, 128, "chain_a", 1'b0, 0);

        // randomized loads against the SRAM model
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < 1024; i++) mem[i] = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                s = 3'($urandom);
            end else begin
                case ($urandom_range(0, 2))
                    0:       s = 3'b001;
                    1:       s = 3'b010;
                    default: s = 3'b100;
                endcase
            end
            lg = ($countones(s) == 1);
            run_load(s, $urandom_range(0, 2), !lg, model_n(s),
                     model_base(s), $sformatf("rnd%0d", r), 1'b0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
